// File: rtl/mult_sequencer.sv
// mult_sequencer
//
// Iterative radix-2 unsigned shift-add multiply controller for the EXE stage.
// A multiply issued by the decoder is latched in IDLE, runs WIDTH add/shift
// steps in BUSY, and its 2*WIDTH-bit product is published in DONE together
// with a one-cycle write-back strobe. While the operation is pending the
// stall output freezes the pipeline (it is ORed into hazard_detected).
//
// Optional feature macro:
//   MULT_ZERO_BYPASS_EN - when defined, a start with a zero operand skips
//                         BUSY and goes straight to DONE with a zero result.
//
// Parameters:
//   WIDTH        operand width (default `WORD_LEN, 32 if not defined)
//   REG_ADDR_LEN destination register index width
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-low reset
//   start      in   issue request, sampled only in IDLE
//   flush      in   abort in-flight operation (branch/jump taken)
//   op_a       in   multiplicand
//   op_b       in   multiplier
//   dest       in   write-back register index
//   busy       out  state != IDLE
//   stall      out  combinational freeze request to the hazard path
//   done       out  one-cycle completion pulse
//   wb_en      out  write-back strobe, equal to done
//   wb_dest    out  latched dest
//   result_hi  out  upper product word
//   result_lo  out  lower product word

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mult_sequencer #(
    parameter int unsigned WIDTH        = `WORD_LEN,
    parameter int unsigned REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        op_a,
    input  logic [WIDTH-1:0]        op_b,
    input  logic [REG_ADDR_LEN-1:0] dest,
    output logic                    busy,
    output logic                    stall,
    output logic                    done,
    output logic                    wb_en,
    output logic [REG_ADDR_LEN-1:0] wb_dest,
    output logic [WIDTH-1:0]        result_hi,
    output logic [WIDTH-1:0]        result_lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e                  state_q,   state_d;
    logic [WIDTH-1:0]        acc_hi_q,  acc_hi_d;
    logic [WIDTH-1:0]        mplr_q,    mplr_d;
    logic [WIDTH-1:0]        mcand_q,   mcand_d;
    logic [CntW-1:0]         count_q,   count_d;
    logic [REG_ADDR_LEN-1:0] wb_dest_q, wb_dest_d;
    logic [WIDTH-1:0]        res_hi_q,  res_hi_d;
    logic [WIDTH-1:0]        res_lo_q,  res_lo_d;

    logic             accept;
    logic             bypass;
    logic             last_step;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign accept = start && !flush;

`ifdef MULT_ZERO_BYPASS_EN
    assign bypass = accept && ((op_a == '0) || (op_b == '0));
`else
    assign bypass = 1'b0;
`endif

    // One shift-add step: add the multiplicand when the current multiplier
    // LSB is set, then shift {carry, acc_hi, mplr} right by one. The product's
    // low word accumulates in mplr as its original bits are shifted out.
    assign sum     = {1'b0, acc_hi_q} + (mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}});
    assign step_hi = sum[WIDTH:1];
    assign step_lo = {sum[0], mplr_q[WIDTH-1:1]};

    assign last_step = (count_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        acc_hi_d  = acc_hi_q;
        mplr_d    = mplr_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        wb_dest_d = wb_dest_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        stall     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    // Stall in the issue cycle so the instruction does not
                    // advance before the sequencer has taken it.
                    stall     = 1'b1;
                    mcand_d   = op_a;
                    mplr_d    = op_b;
                    acc_hi_d  = '0;
                    count_d   = '0;
                    wb_dest_d = dest;
                    if (bypass) begin
                        res_hi_d = '0;
                        res_lo_d = '0;
                        state_d  = StDone;
                    end else begin
                        state_d  = StBusy;
                    end
                end
            end

            StBusy: begin
                stall    = 1'b1;
                acc_hi_d = step_hi;
                mplr_d   = step_lo;
                count_d  = count_q + 1'b1;
                if (flush) begin
                    // Abort wins over completion; results keep old values.
                    state_d = StIdle;
                end else if (last_step) begin
                    res_hi_d = step_hi;
                    res_lo_d = step_lo;
                    state_d  = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            acc_hi_q  <= '0;
            mplr_q    <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            wb_dest_q <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_hi_q  <= acc_hi_d;
            mplr_q    <= mplr_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            wb_dest_q <= wb_dest_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign wb_en     = done;
    assign wb_dest   = wb_dest_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// transaction-level model (accept cycle, completion cycle, exact product).

module tb_mult_sequencer;

    localparam int W  = 32;
    localparam int RA = 5;
`ifdef MULT_ZERO_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic [W-1:0]  op_a  = '0;
    logic [W-1:0]  op_b  = '0;
    logic [RA-1:0] dest  = '0;
    logic          busy, stall, done, wb_en;
    logic [RA-1:0] wb_dest;
    logic [W-1:0]  result_hi, result_lo;

    mult_sequencer #(.WIDTH(W), .REG_ADDR_LEN(RA)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .flush     (flush),
        .op_a      (op_a),
        .op_b      (op_b),
        .dest      (dest),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .wb_en     (wb_en),
        .wb_dest   (wb_dest),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Transaction-level model: an accepted op occupies cycles (k, m_d],
    // completes in cycle m_d, and its product becomes visible in that cycle.
    bit              m_active = 1'b0;
    int              m_d      = 0;
    logic [2*W-1:0]  m_prod   = '0;
    logic [2*W-1:0]  m_res    = '0;
    logic [RA-1:0]   m_wbd    = '0;
    logic [2*W-1:0]  in_prod;

    assign in_prod = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            m_active <= 1'b0;
            m_res    <= '0;
            m_wbd    <= '0;
        end else if (m_active) begin
            if (cyc == m_d || flush) m_active <= 1'b0;
            else if (cyc + 1 == m_d) m_res <= m_prod;
        end else if (start && !flush) begin
            m_active <= 1'b1;
            m_prod   <= in_prod;
            m_wbd    <= dest;
            if (Byp && (op_a == '0 || op_b == '0)) begin
                m_d   <= cyc + 1;
                m_res <= in_prod;
            end else begin
                m_d <= cyc + W + 1;
            end
        end
    end

    // Snapshot of the DUT outputs taken at the last negedge.
    logic           s_busy, s_stall, s_done;
    logic [2*W-1:0] s_res;
    logic [RA-1:0]  s_wbd;
    int             s_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        bit exp_done;
        @(negedge clk);
        s_busy  = busy;
        s_stall = stall;
        s_done  = done;
        s_res   = {result_hi, result_lo};
        s_wbd   = wb_dest;
        s_cyc   = cyc;
        if (chk_en) begin
            exp_done = m_active && (cyc == m_d);
            chk("model busy", 64'(busy), 64'(m_active));
            chk("model done", 64'(done), 64'(exp_done));
            chk("model wb_en", 64'(wb_en), 64'(exp_done));
            chk("model stall", 64'(stall),
                64'(m_active ? (cyc < m_d) : (start && !flush)));
            chk("model result", {result_hi, result_lo}, m_res);
            chk("model wb_dest", 64'(wb_dest), 64'(m_wbd));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RA-1:0] d, output int k, output int sk);
        op_a  = a;
        op_b  = b;
        dest  = d;
        start = 1'b1;
        k     = cyc;
        tick();
        sk    = int'(s_stall);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc, output int nstall);
        dc     = -1;
        nstall = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (s_stall) nstall++;
            if (s_done) begin
                dc = s_cyc;
                break;
            end
        end
        if (dc < 0) begin
            total++;
            bad++;
            $display("FAIL done timeout: got none expected within %0d cycles", budget);
        end
    endtask

    initial begin
        int k, sk, dc, d1, d2, ns, nd;

        // Reset
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset busy", 64'(s_busy), 64'd0);
        chk("reset done", 64'(s_done), 64'd0);
        chk("reset result", s_res, 64'd0);
        chk("reset wb_dest", 64'(s_wbd), 64'd0);
        rst = 1'b1;
        tick();

        // Basic product
        issue(32'd3, 32'd5, 5'd7, k, sk);
        wait_done(100, dc, ns);
        chk("basic latency", 64'(dc - k), 64'd33);
        chk("basic result_lo", s_res[W-1:0], 64'd15);
        chk("basic result_hi", s_res[2*W-1:W], 64'd0);
        chk("basic wb_dest", 64'(s_wbd), 64'd7);
        chk("basic stall cycles", 64'(sk + ns), 64'd33);

        // Full-range product
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, k, sk);
        wait_done(100, dc, ns);
        chk("full result_hi", s_res[2*W-1:W], 64'hFFFF_FFFE);
        chk("full result_lo", s_res[W-1:0], 64'h0000_0001);

        // Flush mid-operation
        issue(32'd9, 32'd9, 5'd1, k, sk);
        while (cyc < k + 10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("flush busy", 64'(s_busy), 64'd0);
        chk("flush stall", 64'(s_stall), 64'd0);
        chk("flush result hold", s_res, 64'hFFFF_FFFE_0000_0001);
        nd = 0;
        repeat (40) begin
            tick();
            if (s_done) nd++;
        end
        chk("flush no done", 64'(nd), 64'd0);
        issue(32'd2, 32'd4, 5'd2, k, sk);
        wait_done(100, dc, ns);
        chk("after flush result_lo", s_res[W-1:0], 64'd8);

        // Held start: back-to-back
        op_a  = 32'd6;
        op_b  = 32'd7;
        dest  = 5'd4;
        start = 1'b1;
        k     = cyc;
        wait_done(100, d1, ns);
        chk("b2b first latency", 64'(d1 - k), 64'd33);
        chk("b2b first result", s_res, 64'd42);
        wait_done(100, d2, ns);
        start = 1'b0;
        chk("b2b interval", 64'(d2 - d1), 64'd34);
        chk("b2b second result", s_res, 64'd42);

        // Reset mid-operation
        issue(32'd1, 32'd1, 5'd9, k, sk);
        while (cyc < k + 5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst-mid busy", 64'(s_busy), 64'd0);
        chk("rst-mid done", 64'(s_done), 64'd0);
        chk("rst-mid result", s_res, 64'd0);
        chk("rst-mid wb_dest", 64'(s_wbd), 64'd0);
        nd = 0;
        repeat (40) begin
            tick();
            if (s_done) nd++;
        end
        chk("rst-mid no done", 64'(nd), 64'd0);

        // Zero operand
        issue(32'd0, 32'd7, 5'd5, k, sk);
        wait_done(100, dc, ns);
        chk("zero latency", 64'(dc - k), Byp ? 64'd1 : 64'd33);
        chk("zero result", s_res, 64'd0);
        chk("zero wb_dest", 64'(s_wbd), 64'd5);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(299) != 0);
            start = ($urandom_range(3) == 0);
            flush = ($urandom_range(24) == 0);
            op_a  = ($urandom_range(5) == 0) ? '0 : W'($urandom);
            op_b  = ($urandom_range(5) == 0) ? '0 : W'($urandom);
            dest  = RA'($urandom);
            tick();
        end
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
